// File: rtl/ext_pkg.sv
// Shared encodings for the immediate-extension pipe: extension modes and skid-buffer states.
// No logic; imported by the datapath and the buffer.
package ext_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'd0,
    MODE_SIGN   = 2'd1,
    MODE_BRANCH = 2'd2,
    MODE_UPPER  = 2'd3
  } ext_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  localparam int MODE_W = 2;

endpackage

// File: rtl/ext_skid_buf.sv
// Two-entry skid buffer (main + skid register), 1-cycle latency, full throughput.
// in_ready is registered and drops only when both entries hold data.
module ext_skid_buf
  import ext_pkg::*;
#(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_e   state;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic         in_xfer;
  logic         out_xfer;

  assign in_xfer   = in_valid && in_ready_q;
  assign out_xfer  = out_valid_q && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // in_ready for next cycle is low only when this edge leaves us FULL
      in_ready_q <= 1'b1;
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_q      <= in_data;
            out_valid_q <= 1'b1;
            state       <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_q <= in_data;
          end else if (in_xfer) begin
            skid_q     <= in_data;
            state      <= ST_FULL;
            in_ready_q <= 1'b0;
          end else if (out_xfer) begin
            out_valid_q <= 1'b0;
            state       <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_q <= skid_q;
            state  <= ST_ONE;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state       <= ST_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate extender (zero/sign/branch/upper) feeding a two-entry skid buffer.
// 1-cycle latency, one word per cycle; stalls via registered in_ready when the buffer fills.
module imm_extend_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SHAMT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_imm,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [1:0]        out_mode
);

  localparam int PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0]        sign_ext;
  logic [OUT_W-1:0]        ext_data;
  logic [OUT_W+MODE_W-1:0] buf_in;
  logic [OUT_W+MODE_W-1:0] buf_out;

  assign sign_ext = {{PAD_W{in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    ext_data = '0;
    case (ext_mode_e'(in_mode))
      MODE_ZERO:   ext_data = {{PAD_W{1'b0}}, in_imm};
      MODE_SIGN:   ext_data = sign_ext;
      MODE_BRANCH: ext_data = sign_ext << SHAMT;
      MODE_UPPER:  ext_data = {in_imm, {PAD_W{1'b0}}};
      default:     ext_data = '0;
    endcase
  end

  // Mode travels with the result so out_mode always matches out_data
  assign buf_in = {in_mode, ext_data};

  ext_skid_buf #(
    .W(OUT_W + MODE_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (buf_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign out_data = buf_out[OUT_W-1:0];
  assign out_mode = buf_out[OUT_W+MODE_W-1:OUT_W];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: driver pushes expected words, a negedge monitor pops and compares.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_mode;

  int checks = 0;
  int failures = 0;
  logic [33:0] exp_q[$];

  logic [15:0] d_imm[6];
  logic [1:0]  d_mode[6];
  logic [31:0] d_exp[6];
  logic [15:0] v_imm[8];
  logic [1:0]  v_mode[8];
  logic [31:0] v_exp[8];

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .SHAMT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] m);
    case (m)
      2'd0:    return {16'h0000, imm};
      2'd1:    return {{16{imm[15]}}, imm};
      2'd2:    return {{14{imm[15]}}, imm, 2'b00};
      default: return {imm, 16'h0000};
    endcase
  endfunction

  // Monitor: every output transfer must match the oldest expected word
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h expected=none", {out_mode, out_data});
        end else begin
          chk("scoreboard", {out_mode, out_data}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] imm, input logic [1:0] m, input logic [31:0] e);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = m;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    chk("send_ready", in_ready, 1);
    if (in_ready) begin
      exp_q.push_back({m, e});
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    d_imm  = '{16'h8004, 16'h8004, 16'h8004, 16'h8004, 16'h7FFF, 16'h7FFF};
    d_mode = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
    d_exp  = '{32'h00008004, 32'hFFFF8004, 32'hFFFE0010, 32'h80040000, 32'h00007FFF, 32'h0001FFFC};
    v_imm  = '{16'h0001, 16'hFFFF, 16'h0001, 16'h1234, 16'h8000, 16'h8000, 16'h4000, 16'hFFFF};
    v_mode = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd2};
    v_exp  = '{32'h00000001, 32'hFFFFFFFF, 32'h00000004, 32'h12340000,
               32'h00008000, 32'hFFFF8000, 32'h00010000, 32'hFFFFFFFC};

    rst_n = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
    #12;
    chk("reset_outputs", {out_valid, in_ready, out_mode, out_data}, 36'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", in_ready, 0);
    tick();
    chk("ready_after_edge", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    // Mode vectors with 1-cycle latency check
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(d_imm[i], d_mode[i], d_exp[i]);
      chk("latency_word", {out_valid, out_mode, out_data}, {1'b1, d_mode[i], d_exp[i]});
    end
    tick(); tick();

    // Back-to-back stream
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_imm = v_imm[i]; in_mode = v_mode[i];
      chk("stream_in_ready", in_ready, 1);
      exp_q.push_back({v_mode[i], v_exp[i]});
      tick();
      chk("stream_out", {out_valid, out_mode, out_data}, {1'b1, v_mode[i], v_exp[i]});
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("stream_drained", exp_q.size(), 0);

    // Backpressure: two words fill the buffer, third waits
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_imm = v_imm[i]; in_mode = v_mode[i];
      chk("bp_in_ready", in_ready, 1);
      exp_q.push_back({v_mode[i], v_exp[i]});
      tick();
    end
    in_imm = v_imm[2]; in_mode = v_mode[2];
    chk("bp_full_ready_low", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold", {out_valid, in_ready, out_mode, out_data}, {2'b10, v_mode[0], v_exp[0]});
    end
    out_ready = 1'b1;
    send(v_imm[2], v_mode[2], v_exp[2]);
    repeat (4) tick();
    chk("bp_drained", exp_q.size(), 0);

    // Random valid/ready traffic
    for (int c = 0; c < 1000; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      in_imm    = 16'($urandom);
      in_mode   = 2'($urandom_range(0, 3));
      if (in_valid && in_ready) exp_q.push_back({in_mode, model(in_imm, in_mode)});
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    chk("random_drained", exp_q.size(), 0);

    // Reset while FULL
    out_ready = 1'b0;
    for (int i = 3; i < 5; i++) begin
      in_valid = 1'b1; in_imm = v_imm[i]; in_mode = v_mode[i];
      exp_q.push_back({v_mode[i], v_exp[i]});
      tick();
    end
    in_valid = 1'b0;
    chk("full_before_reset", {out_valid, in_ready}, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {out_valid, in_ready, out_mode, out_data}, 36'h0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ready_after_reset", {in_ready, out_valid}, 2'b10);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("no_stale_words", out_valid, 0);

    send(d_imm[2], d_mode[2], d_exp[2]);
    repeat (3) tick();
    chk("final_drain", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter IN_W, default 16, SHALL set the immediate input width.
REQ-003 Parameter OUT_W, default 32, SHALL set the extended output width; OUT_W SHALL be greater than IN_W.
REQ-004 Parameter SHAMT, default 2, SHALL set the left-shift amount for branch-offset mode; SHAMT SHALL be less than OUT_W-IN_W.
REQ-005 Port clk, input, 1 bit, SHALL be the rising-edge clock.
REQ-006 Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-007 Port in_valid, input, 1 bit, SHALL mark in_imm and in_mode as valid.
REQ-008 Port in_ready, output, 1 bit, SHALL indicate the block accepts input this cycle.
REQ-009 Port in_imm, input, IN_W bits, SHALL carry the raw immediate.
REQ-010 Port in_mode, input, 2 bits, SHALL select the extension mode.
REQ-011 Port out_valid, output, 1 bit, SHALL mark out_data as valid.
REQ-012 Port out_ready, input, 1 bit, SHALL indicate the consumer accepts output.
REQ-013 Port out_data, output, OUT_W bits, SHALL carry the extended result.
REQ-014 Port out_mode, output, 2 bits, SHALL echo the mode of the word on out_data.

Function
REQ-015 Mode 0 (ZERO) SHALL produce out_data = {(OUT_W-IN_W) zeros, in_imm}.
REQ-016 Mode 1 (SIGN) SHALL replicate in_imm[IN_W-1] into all upper OUT_W-IN_W bits.
REQ-017 Mode 2 (BRANCH) SHALL produce the SIGN result shifted left by SHAMT, with zero fill in the low bits.
REQ-018 Mode 3 (UPPER) SHALL produce in_imm placed in bits [OUT_W-1 : OUT_W-IN_W], with zeros below.
REQ-019 A transfer SHALL occur on a rising clock edge when valid and ready are both high on that side.
REQ-020 Latency SHALL be exactly 1 cycle: a word accepted at edge N SHALL be visible on out_data after edge N when the buffer is empty.
REQ-021 Throughput SHALL be one word per cycle while out_ready stays high.
REQ-022 in_ready SHALL be a registered output that depends on neither in_valid nor out_ready combinationally.
REQ-023 Buffering SHALL be a two-entry skid: a main register and a skid register.
REQ-024 Buffer state EMPTY SHALL transition to ONE on an input transfer.
REQ-025 Buffer state ONE SHALL transition to EMPTY on an output transfer with no input transfer.
REQ-026 Buffer state ONE SHALL transition to FULL on an input transfer with no output transfer.
REQ-027 Buffer state ONE SHALL remain ONE on simultaneous input and output transfers.
REQ-028 Buffer state FULL SHALL transition to ONE on an output transfer, with the skid entry moving to the main register.
REQ-029 in_ready SHALL be low exactly in FULL.
REQ-030 While out_valid is high and out_ready is low, out_data and out_mode SHALL remain stable.
REQ-031 Words SHALL leave the block in acceptance order; none SHALL be dropped or duplicated.
REQ-032 When in_valid is low, in_imm and in_mode SHALL be ignored.

Reset
REQ-033 Asserting rst_n low SHALL immediately force out_valid to 0, in_ready to 0, out_data to 0, out_mode to 0 and the state to EMPTY, including mid-transfer.
REQ-034 in_ready SHALL rise on the first clock edge after rst_n deasserts.

Structure
REQ-035 Mode encodings ZERO, SIGN, BRANCH and UPPER, and the buffer-state encoding, SHALL live in a shared package ext_pkg.
REQ-036 Extension logic SHALL be combinational ahead of the buffer, so that only computed results are stored.
REQ-037 The buffer SHALL be one sub-module, ext_skid_buf, parameterised by data width (OUT_W+2).

Verification (defaults IN_W=16, OUT_W=32, SHAMT=2)
REQ-038 in_imm=16'h8004, modes 0/1/2/3 with out_ready=1 -> 32'h00008004, 32'hFFFF8004, 32'hFFFE0010, 32'h80040000, each 1 cycle after acceptance.
REQ-039 Stream 8 words back-to-back with out_ready=1 -> 8 outputs on 8 consecutive cycles, in order, with in_ready held at 1.
REQ-040 out_ready=0 while 3 words are offered -> 2 accepted, in_ready=0 after the second, out_data held at word 1; releasing out_ready -> words 1, 2, 3 delivered in order.
REQ-041 Random in_valid and out_ready over 1000 cycles -> output sequence matches a reference queue, with no loss or duplication.
REQ-042 Assert rst_n low while in FULL -> out_valid=0 and in_ready=0 asynchronously; in_ready=1 one edge after release; no stale words emerge.
REQ-043 in_imm=16'h7FFF, mode 1 -> 32'h00007FFF; mode 2 -> 32'h0001FFFC.
